// File: rtl/boolexp_sweep_ctrl.sv
// boolexp_sweep_ctrl: exhaustive 4-input truth-table sweep and check
// for a combinational Boolean-expression datapath under test.
//
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start           begin a sweep (honoured in IDLE only)
//   abort           cancel a sweep (honoured in DRIVE only)
//   exp_tt[15:0]    expected truth table, latched on accepted start
//   y               datapath output, combinational from a..d
//   a,b,c,d         datapath inputs, {a,b,c,d} = vector index
//   busy            high while sweeping or checking
//   done            one-cycle pulse at sweep completion
//   pass            captured table matches expected table
//   tt[15:0]        captured truth table
//   err_cnt[4:0]    number of mismatching vectors
//   err_idx[3:0]    first mismatching vector index

module boolexp_sweep_ctrl #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_tt,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt,
  output logic [4:0]  err_cnt,
  output logic [3:0]  err_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  cnt;
  logic [15:0] exp_q;

  // idx is a register, so a..d are registered outputs.
  assign {a, b, c, d} = idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      exp_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      tt      <= '0;
      err_cnt <= '0;
      err_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= DRIVE;
            exp_q   <= exp_tt;
            idx     <= '0;
            cnt     <= '0;
            tt      <= '0;
            err_cnt <= '0;
            err_idx <= '0;
            pass    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        DRIVE: begin
          if (abort) begin
            // Partial results are left visible.
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            tt[idx] <= y;
            cnt     <= '0;
            if (y != exp_q[idx]) begin
              err_cnt <= err_cnt + 5'd1;
              if (err_cnt == 5'd0)
                err_idx <= idx;
            end
            // Hold 1111 through CHECK.
            if (idx == 4'hF)
              state <= CHECK;
            else
              idx <= idx + 4'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CHECK: begin
          pass  <= (tt == exp_q);
          done  <= 1'b1;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boolexp_sweep_ctrl.sv
// tb_boolexp_sweep_ctrl: directed sweeps with a per-cycle reference
// model of the sweep outcome plus literal spot checks.

module tb_boolexp_sweep_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_tt = '0;
  logic        y;
  logic        a, b, c, d;
  logic        busy, done, pass;
  logic [15:0] tt;
  logic [4:0]  err_cnt;
  logic [3:0]  err_idx;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int ymode = 0;

  boolexp_sweep_ctrl #(.DWELL(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .exp_tt  (exp_tt),
    .y       (y),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .tt      (tt),
    .err_cnt (err_cnt),
    .err_idx (err_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath under test: parity of the inputs, or stuck at 0.
  function automatic logic fy(input int j);
    logic [3:0] v;
    v = 4'(j);
    return (ymode == 0) ? ^v : 1'b0;
  endfunction

  always_comb y = fy({28'd0, a, b, c, d});

  // Reference model: results after the first k vectors are sampled.
  function automatic void partial(input int k, input logic [15:0] e,
                                  output logic [15:0] t,
                                  output logic [4:0] n,
                                  output logic [3:0] fi);
    t = '0; n = '0; fi = '0;
    for (int j = 0; j < k; j++) begin
      t[j] = fy(j);
      if (t[j] != e[j]) begin
        if (n == 0) fi = 4'(j);
        n = n + 5'd1;
      end
    end
  endfunction

  bit          m_valid = 0;
  bit          m_act = 0;
  int          m_n = 0;
  logic [15:0] m_exp = '0;
  logic [15:0] r_tt = '0;
  logic [4:0]  r_cnt = '0;
  logic [3:0]  r_idx = '0;
  logic        r_pass = 0;
  logic        m_done = 0;

  function automatic logic [33:0] model_out();
    logic [15:0] t;
    logic [4:0]  n;
    logic [3:0]  fi;
    int          v;
    if (m_act) begin
      v = m_n / D;
      partial((v > 16) ? 16 : v, m_exp, t, n, fi);
      if (v > 15) v = 15;
      return {4'(v), 1'b1, 1'b0, 1'b0, t, n, fi};
    end
    return {4'd0, 1'b0, m_done, r_pass, r_tt, r_cnt, r_idx};
  endfunction

  always @(posedge clk) begin
    logic [33:0] e, g;
    int nn;
    if (!rst_n) begin
      m_valid = 1; m_act = 0; m_done = 0;
      r_tt = '0; r_cnt = '0; r_idx = '0; r_pass = 0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_n = 0; m_exp = exp_tt;
          r_pass = 0;
        end
      end else begin
        nn = m_n + 1;
        if (abort && nn <= 16 * D) begin
          m_act = 0;
          partial((nn - 1) / D, m_exp, r_tt, r_cnt, r_idx);
        end else if (nn == 16 * D + 1) begin
          m_act = 0; m_done = 1;
          partial(16, m_exp, r_tt, r_cnt, r_idx);
          r_pass = (r_tt == m_exp);
        end else begin
          m_n = nn;
        end
      end
    end
    #1;
    if (m_valid) begin
      e = model_out();
      g = {a, b, c, d, busy, done, pass, tt, err_cnt, err_idx};
      vecs++;
      if (g !== e) begin
        errs++;
        $display("FAIL cycle %0d outputs: got %h want %h", cyc, g, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  // Start a sweep; returns start-to-done latency and busy cycle count.
  task automatic sweep(input logic [15:0] e, input int mode,
                       input int restart_at, output int lat,
                       output int bcnt);
    int t0;
    @(negedge clk);
    ymode = mode; exp_tt = e; start = 1;
    @(posedge clk); #1;
    t0 = cyc; lat = -1; bcnt = busy ? 1 : 0;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == restart_at) start = 1;
      if (i == restart_at + 1) start = 0;
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    start = 0;
    if (lat < 0) chk("sweep_timeout", 0, 1);
  endtask

  initial begin
    int lat, bc;
    bit saw;
    repeat (3) @(negedge clk);
    chk("rst_outs", {a, b, c, d, busy, done, pass, tt, err_cnt, err_idx},
        0);
    rst_n = 1;

    sweep(16'h6996, 0, -5, lat, bc);
    chk("t2_lat", lat, 65);
    chk("t2_busy", bc, 65);
    chk("t2_pass", pass, 1);
    chk("t2_tt", tt, 16'h6996);
    chk("t2_cnt", err_cnt, 0);

    sweep(16'h6997, 0, -5, lat, bc);
    chk("t3_pass", pass, 0);
    chk("t3_cnt", err_cnt, 1);
    chk("t3_idx", err_idx, 0);
    chk("t3_tt", tt, 16'h6996);

    sweep(16'hFFFF, 1, -5, lat, bc);
    chk("t4_cnt", err_cnt, 16);
    chk("t4_idx", err_idx, 0);
    chk("t4_pass", pass, 0);
    chk("t4_tt", tt, 16'h0000);

    // Abort 20 cycles in: vectors 0..3 sampled (parity 0,1,1,0).
    @(negedge clk);
    ymode = 0; exp_tt = 16'h6996; start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    abort = 1;
    @(posedge clk); #1;
    chk("t5_busy", busy, 0);
    chk("t5_abcd", {a, b, c, d}, 0);
    chk("t5_tt", tt, 16'h0006);
    @(negedge clk);
    abort = 0;
    saw = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    chk("t5_nodone", saw, 0);
    chk("t5_pass", pass, 0);

    sweep(16'h6996, 0, 10, lat, bc);
    chk("t6_lat", lat, 65);
    chk("t6_pass", pass, 1);

    // Back-to-back: start in the first IDLE cycle after CHECK.
    sweep(16'h6996, 0, -5, lat, bc);
    chk("t7_lat", lat, 65);

    @(negedge clk);
    exp_tt = 16'h1234; start = 1;
    @(negedge clk);
    start = 0;
    repeat (30) @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    chk("t6_rst", {a, b, c, d, busy, done, pass, tt, err_cnt, err_idx},
        0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
